// File: rtl/glb_psum_reader.sv
// Reads a burst of psum words from one cluster's GLB read port and streams them
// out through a small credit-protected FIFO with valid/ready handshaking.
module glb_psum_reader #(
  parameter int DATA_BITWIDTH = 16,
  parameter int ADDR_BITWIDTH = 10,
  parameter int FIFO_DEPTH    = 4,
  parameter int CNT_BITWIDTH  = 11
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     abort,
  input  logic [ADDR_BITWIDTH-1:0] base_addr,
  input  logic [CNT_BITWIDTH-1:0]  num_words,
  output logic                     r_req_psum,
  output logic [ADDR_BITWIDTH-1:0] r_addr_psum,
  input  logic [DATA_BITWIDTH-1:0] r_data_psum,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_BITWIDTH-1:0] out_data,
  output logic                     out_last,
  output logic                     busy,
  output logic                     done
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W:0] DEPTH_L = FIFO_DEPTH[OCC_W:0];

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t                    state;
  logic [DATA_BITWIDTH-1:0]  mem [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]     mem_last;
  logic [PTR_W-1:0]          wr_ptr;
  logic [PTR_W-1:0]          rd_ptr;
  logic [OCC_W-1:0]          count;
  logic [OCC_W-1:0]          count_next;
  logic [OCC_W:0]            pending;
  logic [CNT_BITWIDTH-1:0]   nwords;
  logic [CNT_BITWIDTH-1:0]   issue_idx;
  logic                      req_last_p0;
  logic                      vld_p1;
  logic                      last_p1;
  logic                      push;
  logic                      pop;
  logic                      credit;

  assign push       = vld_p1;
  assign pop        = out_valid & out_ready;
  assign count_next = count + OCC_W'(push) - OCC_W'(pop);

  // Words already buffered, on the data bus now, and requested last cycle;
  // a pop in this cycle is deliberately not credited.
  assign pending = {1'b0, count} + (OCC_W+1)'(vld_p1) + (OCC_W+1)'(r_req_psum);
  assign credit  = pending < DEPTH_L;

  assign out_valid = (count != '0);
  assign out_data  = out_valid ? mem[rd_ptr] : '0;
  assign out_last  = out_valid & mem_last[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr]      <= r_data_psum;
      mem_last[wr_ptr] <= last_p1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      r_req_psum  <= 1'b0;
      r_addr_psum <= '0;
      req_last_p0 <= 1'b0;
      vld_p1      <= 1'b0;
      last_p1     <= 1'b0;
      nwords      <= '0;
      issue_idx   <= '0;
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      // ---- request stage -> capture stage ----
      done        <= 1'b0;
      r_req_psum  <= 1'b0;
      req_last_p0 <= 1'b0;
      vld_p1      <= r_req_psum;
      last_p1     <= req_last_p0;
      count       <= count_next;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);

      case (state)
        IDLE: begin
          if (start) begin
            if (num_words != '0) begin
              // First request goes out on the latch edge to keep start-to-data at 3 cycles.
              nwords      <= num_words;
              issue_idx   <= CNT_BITWIDTH'(1);
              r_req_psum  <= 1'b1;
              r_addr_psum <= base_addr;
              busy        <= 1'b1;
              if (num_words == CNT_BITWIDTH'(1)) begin
                req_last_p0 <= 1'b1;
                state       <= DRAIN;
              end else begin
                state <= READ;
              end
            end else begin
              done <= 1'b1;
            end
          end
        end

        READ: begin
          if (abort) begin
            state   <= IDLE;
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
            count   <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            busy    <= 1'b0;
          end else if (credit) begin
            r_req_psum  <= 1'b1;
            r_addr_psum <= r_addr_psum + ADDR_BITWIDTH'(1);
            issue_idx   <= issue_idx + CNT_BITWIDTH'(1);
            if (issue_idx == nwords - CNT_BITWIDTH'(1)) begin
              req_last_p0 <= 1'b1;
              state       <= DRAIN;
            end
          end
        end

        DRAIN: begin
          if (abort) begin
            state   <= IDLE;
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
            count   <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            busy    <= 1'b0;
          end else if (!r_req_psum && !vld_p1 && count_next == '0) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_glb_psum_reader.sv
// Directed bench for glb_psum_reader with a GLB model returning mem[a] = a + 0x100.
module tb_glb_psum_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic [9:0]  base_addr;
  logic [10:0] num_words;
  logic        r_req_psum;
  logic [9:0]  r_addr_psum;
  logic [15:0] r_data_psum;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_last;
  logic        busy;
  logic        done;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  logic [15:0] rx_data [$];
  logic        rx_last [$];
  logic [9:0]  req_q [$];
  int          done_cnt = 0;

  glb_psum_reader dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .base_addr  (base_addr),
    .num_words  (num_words),
    .r_req_psum (r_req_psum),
    .r_addr_psum(r_addr_psum),
    .r_data_psum(r_data_psum),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // GLB read port: data valid the cycle after the request
  always @(posedge clk) begin
    if (r_req_psum) r_data_psum <= {6'd0, r_addr_psum} + 16'h0100;
    else            r_data_psum <= 16'hBAD0;
  end

  always @(posedge clk) begin
    if (out_valid && out_ready) begin
      rx_data.push_back(out_data);
      rx_last.push_back(out_last);
    end
    if (r_req_psum) req_q.push_back(r_addr_psum);
    if (done) done_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    rx_data.delete();
    rx_last.delete();
    req_q.delete();
    done_cnt = 0;
  endtask

  task automatic pulse_start(input logic [9:0] b, input logic [10:0] n);
    base_addr = b;
    num_words = n;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < budget; k++) begin
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    if (done === 1'b1) seen = 1'b1;
    check(tag, {31'd0, seen}, 32'd1);
  endtask

  task automatic check_burst(input string tag, input logic [15:0] first, input int n);
    check({tag, "_count"}, rx_data.size(), n);
    for (int i = 0; i < n && i < rx_data.size(); i++) begin
      check({tag, "_data"}, {16'd0, rx_data[i]}, {16'd0, first + 16'(i)});
      check({tag, "_last"}, {31'd0, rx_last[i]}, {31'd0, (i == n - 1)});
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    base_addr = '0; num_words = '0; out_ready = 1'b0;
    tick(); tick();
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_r_req",     {31'd0, r_req_psum}, 32'd0);
    check("rst_r_addr",    {22'd0, r_addr_psum}, 32'd0);
    check("rst_busy",      {31'd0, busy}, 32'd0);
    check("rst_done",      {31'd0, done}, 32'd0);
    check("rst_out_data",  {16'd0, out_data}, 32'd0);
    reset = 1'b0;
    tick();
    clear_logs();

    // Basic burst with cycle-exact latency
    out_ready = 1'b1;
    pulse_start(10'h010, 11'd5);
    check("b_busy",       {31'd0, busy}, 32'd1);
    check("b_req0",       {31'd0, r_req_psum}, 32'd1);
    check("b_addr0",      {22'd0, r_addr_psum}, 32'h010);
    check("b_valid_c1",   {31'd0, out_valid}, 32'd0);
    tick();
    check("b_addr1",      {22'd0, r_addr_psum}, 32'h011);
    check("b_valid_c2",   {31'd0, out_valid}, 32'd0);
    tick();
    for (int i = 0; i < 5; i++) begin
      check("b_valid", {31'd0, out_valid}, 32'd1);
      check("b_data",  {16'd0, out_data}, 32'h110 + i);
      check("b_last",  {31'd0, out_last}, {31'd0, (i == 4)});
      check("b_nodone", {31'd0, done}, 32'd0);
      if (i < 4) tick();
    end
    tick();
    check("b_done",       {31'd0, done}, 32'd1);
    check("b_busy_off",   {31'd0, busy}, 32'd0);
    check("b_empty",      {31'd0, out_valid}, 32'd0);
    tick();
    check("b_done_pulse", {31'd0, done}, 32'd0);
    check("b_req_count",  req_q.size(), 5);
    for (int i = 0; i < 5 && i < req_q.size(); i++)
      check("b_req_addr", {22'd0, req_q[i]}, 32'h010 + i);
    check_burst("b", 16'h0110, 5);
    check("b_done_cnt",   done_cnt, 1);

    // Backpressure: credit limits outstanding words to FIFO_DEPTH
    clear_logs();
    out_ready = 1'b0;
    pulse_start(10'h010, 11'd10);
    for (int k = 0; k < 20; k++) begin
      tick();
      if (k == 9 || k == 19) begin
        check("bp_valid", {31'd0, out_valid}, 32'd1);
        check("bp_hold",  {16'd0, out_data}, 32'h110);
      end
    end
    check("bp_req_stall", req_q.size(), 4);
    out_ready = 1'b1;
    wait_done(40, "bp_done_seen");
    tick();
    check_burst("bp", 16'h0110, 10);
    check("bp_req_count", req_q.size(), 10);
    check("bp_done_cnt",  done_cnt, 1);

    // Address wrap past 0x3FF
    clear_logs();
    pulse_start(10'h3FE, 11'd4);
    wait_done(20, "wr_done_seen");
    tick();
    check("wr_req_count", req_q.size(), 4);
    if (req_q.size() == 4) begin
      check("wr_a0", {22'd0, req_q[0]}, 32'h3FE);
      check("wr_a1", {22'd0, req_q[1]}, 32'h3FF);
      check("wr_a2", {22'd0, req_q[2]}, 32'h000);
      check("wr_a3", {22'd0, req_q[3]}, 32'h001);
    end
    check("wr_count", rx_data.size(), 4);
    if (rx_data.size() == 4) begin
      check("wr_d0", {16'd0, rx_data[0]}, 32'h4FE);
      check("wr_d1", {16'd0, rx_data[1]}, 32'h4FF);
      check("wr_d2", {16'd0, rx_data[2]}, 32'h100);
      check("wr_d3", {16'd0, rx_data[3]}, 32'h101);
    end

    // Empty burst
    clear_logs();
    pulse_start(10'h055, 11'd0);
    check("e_done",  {31'd0, done}, 32'd1);
    check("e_busy",  {31'd0, busy}, 32'd0);
    check("e_req",   {31'd0, r_req_psum}, 32'd0);
    tick();
    check("e_done_pulse", {31'd0, done}, 32'd0);
    tick();
    check("e_req_count",  req_q.size(), 0);

    // Start ignored while busy
    clear_logs();
    pulse_start(10'h020, 11'd8);
    tick(); tick();
    check("ig_busy", {31'd0, busy}, 32'd1);
    pulse_start(10'h200, 11'd3);
    wait_done(40, "ig_done_seen");
    tick(); tick(); tick();
    check_burst("ig", 16'h0120, 8);
    check("ig_req_count", req_q.size(), 8);
    check("ig_done_cnt",  done_cnt, 1);

    // Abort after three delivered words
    clear_logs();
    pulse_start(10'h040, 11'd8);
    for (int k = 0; k < 30; k++) begin
      if (rx_data.size() >= 3) break;
      tick();
    end
    check("ab_three", rx_data.size(), 3);
    abort = 1'b1;
    out_ready = 1'b0;
    tick();
    abort = 1'b0;
    check("ab_valid", {31'd0, out_valid}, 32'd0);
    check("ab_busy",  {31'd0, busy}, 32'd0);
    check("ab_req",   {31'd0, r_req_psum}, 32'd0);
    check("ab_done",  {31'd0, done}, 32'd0);
    out_ready = 1'b1;
    tick();
    check("ab_discard", {31'd0, out_valid}, 32'd0);
    tick(); tick();
    check("ab_no_done", done_cnt, 0);
    check("ab_rx_kept", rx_data.size(), 3);
    clear_logs();
    pulse_start(10'h080, 11'd3);
    wait_done(20, "ab_fresh_done_seen");
    tick();
    check_burst("ab_fresh", 16'h0180, 3);
    check("ab_fresh_req", req_q.size(), 3);
    if (req_q.size() == 3) check("ab_fresh_a0", {22'd0, req_q[0]}, 32'h080);

    // Asynchronous reset during READ
    clear_logs();
    out_ready = 1'b0;
    pulse_start(10'h100, 11'd8);
    tick(); tick(); tick();
    check("rm_pre_valid", {31'd0, out_valid}, 32'd1);
    #3 reset = 1'b1;
    #1;
    check("rm_valid", {31'd0, out_valid}, 32'd0);
    check("rm_req",   {31'd0, r_req_psum}, 32'd0);
    check("rm_addr",  {22'd0, r_addr_psum}, 32'd0);
    check("rm_busy",  {31'd0, busy}, 32'd0);
    check("rm_data",  {16'd0, out_data}, 32'd0);
    check("rm_last",  {31'd0, out_last}, 32'd0);
    tick();
    reset = 1'b0;
    tick();
    check("rm_empty_after", {31'd0, out_valid}, 32'd0);
    clear_logs();
    out_ready = 1'b1;
    pulse_start(10'h005, 11'd2);
    wait_done(20, "rm_post_done_seen");
    tick();
    check_burst("rm_post", 16'h0105, 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
